// File: rtl/fetch_pkg.sv
// Shared defaults, FSM state type and in-flight tag layout for the fetch PC unit.
package fetch_pkg;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    FLUSH
  } fetch_state_e;

  typedef struct packed {
    logic                    epoch;
    logic [XLEN_DEFAULT-1:0] pc;
  } fetch_tag_t;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-unit bus: imem request/response channel plus the decode-facing queue head.
interface fetch_pc_unit_if #(
  parameter int unsigned XLEN = fetch_pkg::XLEN_DEFAULT
);
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            dec_valid;
  logic [31:0]     dec_inst;
  logic [XLEN-1:0] dec_pc;
  logic            dec_ready;

  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_inst, dec_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_inst, dec_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; any depth >= 1. Push on full is accepted only with a pop.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + CntW'(1);
      else if (!do_push && do_pop) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only slots covered by count are ever read out.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: issues imem requests, tags them with an epoch, queues in-epoch responses.
// Optional FETCH_MISALIGN_EN adds a registered redirect_misalign pulse output.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEFAULT),
  parameter int unsigned     FQ_DEPTH  = 4,
  parameter int unsigned     MAX_OUTST = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_target,
  input  logic                   stall,
  fetch_pc_unit_if.master        bus,
  output logic [XLEN-1:0]        pc_next_out
`ifdef FETCH_MISALIGN_EN
  ,
  output logic                   redirect_misalign
`endif
);
  localparam int unsigned OutW = $clog2(MAX_OUTST + 1);
  localparam int unsigned OccW = $clog2(FQ_DEPTH + 1);
  localparam int unsigned SumW = ((OutW > OccW) ? OutW : OccW) + 1;
  localparam logic [XLEN-1:0] AlignMask = {{(XLEN - 2){1'b1}}, 2'b00};

  typedef struct packed {
    logic            epoch;
    logic [XLEN-1:0] pc;
  } tag_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } entry_t;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, target_aligned;
  logic            epoch_q;
  logic            redirect_take, req_fire, rsp_take, can_issue;
  logic            tag_full, tag_empty, q_full, q_empty, q_push, q_pop;
  logic [OutW-1:0] outst;
  logic [OccW-1:0] occ;
  tag_t            tag_new, tag_head;
  entry_t          q_new, q_head;

  assign target_aligned = redirect_target & AlignMask;
  assign redirect_take  = redirect_valid && (state_q != BOOT);
  assign req_fire       = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_take       = bus.imem_rsp_valid && !tag_empty;
  assign q_push         = rsp_take && (tag_head.epoch == epoch_q);
  assign q_pop          = bus.dec_valid && bus.dec_ready;
  // Credit: every in-flight request already owns a queue slot, so responses never overflow.
  assign can_issue      = !stall && !tag_full && !q_full &&
                          ((SumW'(outst) + SumW'(occ)) < SumW'(FQ_DEPTH));

  assign tag_new = '{epoch: epoch_q, pc: pc_q};
  assign q_new   = '{pc: tag_head.pc, inst: bus.imem_rsp_data};

  fetch_fifo #(
    .WIDTH ($bits(tag_t)),
    .DEPTH (MAX_OUTST)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_fire),
    .wdata (tag_new),
    .pop   (rsp_take),
    .flush (1'b0),
    .rdata (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (outst)
  );

  fetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .wdata (q_new),
    .pop   (q_pop),
    .flush (redirect_take),
    .rdata (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (occ)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= BOOT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:         state_d = FETCH;
      FETCH, FLUSH: state_d = redirect_take ? FLUSH : FETCH;
      default:      state_d = BOOT;
    endcase
  end

  always_comb begin
    bus.imem_req_valid = 1'b0;
    if (state_q == FETCH) bus.imem_req_valid = can_issue;
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect_take) pc_d = target_aligned;
    else if (req_fire) pc_d = pc_q + XLEN'(4);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      epoch_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      epoch_q <= epoch_q ^ redirect_take;
    end
  end

  assign bus.imem_req_addr = pc_q;
  assign bus.dec_valid     = !q_empty;
  assign bus.dec_inst      = q_empty ? '0 : q_head.inst;
  assign bus.dec_pc        = q_empty ? '0 : q_head.pc;
  assign pc_next_out       = redirect_valid ? target_aligned : pc_q;

`ifdef FETCH_MISALIGN_EN
  logic misalign_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) misalign_q <= 1'b0;
    else      misalign_q <= redirect_take && (redirect_target[1:0] != 2'b00);
  end

  assign redirect_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized bench for fetch_pc_unit against a queue-based reference of the fetch stream.
module tb_fetch_pc_unit;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned FQ_DEPTH  = 4;
  localparam int unsigned MAX_OUTST = 2;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        stall = 1'b0;
  logic [31:0] pc_next_out;
`ifdef FETCH_MISALIGN_EN
  logic        redirect_misalign;
`endif

  fetch_pc_unit_if #(.XLEN(XLEN)) bus ();

  fetch_pc_unit #(
    .XLEN      (XLEN),
    .RESET_PC  (RESET_PC),
    .FQ_DEPTH  (FQ_DEPTH),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .stall           (stall),
    .bus             (bus),
    .pc_next_out     (pc_next_out)
`ifdef FETCH_MISALIGN_EN
    ,
    .redirect_misalign (redirect_misalign)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: requested-but-unanswered addresses (oldest n_stale are squashed),
  // the PCs decode should see in order, and the next fetch PC.
  logic [31:0] pending[$];
  logic [31:0] fq[$];
  int          n_stale = 0;
  logic [31:0] mpc = RESET_PC;
  bit          in_boot = 1'b1;
  bit          in_flush = 1'b0;
  bit          exp_mis = 1'b0;
  int          p_ready = 100, p_rsp = 100, p_dec = 100, p_stall = 0;
  bit          ghost = 1'b0;
  int          dut_fires = 0;
  bit          wrap_watch = 1'b0;
  bit          saw_zero = 1'b0;

  function automatic logic [31:0] inst_of(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit redir, logic [31:0] tgt);
    redirect_valid     = redir;
    redirect_target    = redir ? tgt : $urandom;
    stall              = ($urandom_range(99) < p_stall);
    bus.imem_req_ready = ($urandom_range(99) < p_ready);
    bus.dec_ready      = ($urandom_range(99) < p_dec);
    bus.imem_rsp_valid = ghost || ((pending.size() != 0) && ($urandom_range(99) < p_rsp));
    bus.imem_rsp_data  = (pending.size() != 0) ? inst_of(pending[0]) : $urandom;
  endtask

  task automatic model_check();
    logic [31:0] tgt_al;
    logic [31:0] a;
    bit          taken, exp_req;
    tgt_al  = redirect_target & 32'hFFFF_FFFC;
    taken   = redirect_valid && !in_boot;
    exp_req = !in_boot && !in_flush && !stall && (pending.size() < MAX_OUTST) &&
              ((pending.size() + fq.size()) < FQ_DEPTH);
    chk("req_valid", 64'(bus.imem_req_valid), 64'(exp_req));
    if (exp_req) chk("req_addr", 64'(bus.imem_req_addr), 64'(mpc));
    chk("pc_next_out", 64'(pc_next_out), 64'(redirect_valid ? tgt_al : mpc));
    chk("dec_valid", 64'(bus.dec_valid), 64'(fq.size() != 0));
    if (fq.size() != 0) begin
      chk("dec_pc", 64'(bus.dec_pc), 64'(fq[0]));
      chk("dec_inst", 64'(bus.dec_inst), 64'(inst_of(fq[0])));
    end
`ifdef FETCH_MISALIGN_EN
    chk("misalign", 64'(redirect_misalign), 64'(exp_mis));
`endif
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      dut_fires++;
      if (wrap_watch && bus.imem_req_addr == 32'h0) saw_zero = 1'b1;
    end
    // Advance the reference across the coming clock edge.
    if ((fq.size() != 0) && bus.dec_ready) void'(fq.pop_front());
    if (bus.imem_rsp_valid && (pending.size() != 0)) begin
      a = pending.pop_front();
      if (n_stale > 0) n_stale--;
      else fq.push_back(a);
    end
    if (exp_req && bus.imem_req_ready) begin
      pending.push_back(mpc);
      mpc = mpc + 32'd4;
    end
    exp_mis  = taken && (redirect_target[1:0] != 2'b00);
    in_boot  = 1'b0;
    in_flush = taken;
    if (taken) begin
      n_stale = pending.size();
      fq.delete();
      mpc = tgt_al;
    end
  endtask

  task automatic step(bit redir, logic [31:0] tgt);
    drive(redir, tgt);
    #1;
    model_check();
    @(negedge clk);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      if (p_stall > 0 && $urandom_range(99) < 4) step(1'b1, $urandom);
      else step(1'b0, 32'h0);
    end
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("rst_req_valid", 64'(bus.imem_req_valid), 64'(0));
    chk("rst_dec_valid", 64'(bus.dec_valid), 64'(0));
    chk("rst_dec_inst", 64'(bus.dec_inst), 64'(0));
    chk("rst_dec_pc", 64'(bus.dec_pc), 64'(0));
    chk("rst_pc_next", 64'(pc_next_out), 64'(RESET_PC));
`ifdef FETCH_MISALIGN_EN
    chk("rst_misalign", 64'(redirect_misalign), 64'(0));
`endif
    pending.delete();
    fq.delete();
    n_stale  = 0;
    mpc      = RESET_PC;
    in_boot  = 1'b1;
    in_flush = 1'b0;
    exp_mis  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic set_knobs(int r, int s, int d, int st);
    p_ready = r; p_rsp = s; p_dec = d; p_stall = st;
  endtask

  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.dec_ready      = 1'b0;
    @(negedge clk);
    do_reset();

    // Straight-line fetch from RESET_PC with immediate responses.
    set_knobs(100, 100, 100, 0);
    run(20);

    // Decode blocked: exactly FQ_DEPTH requests may issue from an idle state.
    set_knobs(0, 100, 100, 0);
    run(8);
    set_knobs(100, 100, 0, 0);
    dut_fires = 0;
    run(10);
    chk("fill_count", 64'(dut_fires), 64'(FQ_DEPTH));
    chk("fill_stop", 64'(bus.imem_req_valid), 64'(0));
    set_knobs(100, 100, 100, 0);
    run(10);

    // Redirect with two requests in flight: both responses must be squashed.
    set_knobs(0, 100, 100, 0);
    run(8);
    set_knobs(100, 0, 100, 0);
    run(2);
    set_knobs(0, 0, 100, 0);
    step(1'b1, 32'h0000_0100);
    set_knobs(100, 100, 100, 0);
    run(12);

    // Request handshaking in the redirect cycle itself.
    set_knobs(0, 100, 100, 0);
    run(8);
    set_knobs(100, 0, 100, 0);
    step(1'b1, 32'h0000_0200);
    set_knobs(100, 100, 100, 0);
    run(12);

    // PC wrap at the top of the address space, then a misaligned redirect.
    wrap_watch = 1'b1;
    step(1'b1, 32'hFFFF_FFF8);
    run(8);
    wrap_watch = 1'b0;
    chk("wrap_addr0", 64'(saw_zero), 64'(1));
    step(1'b1, 32'h0000_0103);
    run(10);

    // Random traffic with stalls and redirects.
    set_knobs(70, 60, 60, 20);
    run(400);

    // Reset mid-burst, a stray response right after release, then more traffic.
    set_knobs(100, 30, 20, 0);
    run(15);
    do_reset();
    ghost = 1'b1;
    step(1'b0, 32'h0);
    ghost = 1'b0;
    set_knobs(100, 100, 100, 0);
    run(3);
    set_knobs(60, 50, 70, 15);
    run(300);
    set_knobs(100, 100, 100, 0);
    run(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
